// File: rtl/addsub_result_buffer.sv
// addsub_result_buffer: first-word-fall-through FIFO buffering adder/subtractor results with overflow flags
//
// Parameters
//   n      data width of the adder/subtractor result
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   Clock     in   sole clock, rising edge
//   Reset     in   asynchronous active-low reset
//   Z         in   result word from the adder/subtractor
//   Overflow  in   overflow flag accompanying Z
//   InValid   in   push request for Z/Overflow
//   OutReady  in   consumer takes the head entry this cycle
//   OutData   out  head entry data (0 when empty)
//   OutOvf    out  head entry overflow flag (0 when empty)
//   OutValid  out  buffer non-empty
//   Full      out  occupancy == DEPTH
//   Dropped   out  sticky: a push was refused because the buffer was full
//   OvfCount  out  saturating (at 15) count of accepted entries flagged Overflow
//
// Build option
//   SAT_ON_OVERFLOW_EN  when defined, overflowed results are clamped to the
//                       signed extreme matching the true sign at push time
module addsub_result_buffer #(
    parameter int n     = 5,
    parameter int DEPTH = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [n-1:0] Z,
    input  logic         Overflow,
    input  logic         InValid,
    input  logic         OutReady,
    output logic [n-1:0] OutData,
    output logic         OutOvf,
    output logic         OutValid,
    output logic         Full,
    output logic         Dropped,
    output logic [3:0]   OvfCount
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [n:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_dropped;
    logic [3:0]    r_ovf_cnt;
    logic          w_push;
    logic          w_pop;
    logic [n-1:0]  w_data;

    assign OutValid = r_count != '0;
    assign Full     = r_count == CW'(DEPTH);
    assign w_pop    = OutValid && OutReady;
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign w_push   = InValid && (!Full || w_pop);
    assign OutData  = OutValid ? r_mem[r_rptr][n-1:0] : '0;
    assign OutOvf   = OutValid && r_mem[r_rptr][n];
    assign Dropped  = r_dropped;
    assign OvfCount = r_ovf_cnt;

`ifdef SAT_ON_OVERFLOW_EN
    // An overflowed result has the wrong sign bit, so a set MSB means the true
    // value was positive: clamp to the opposite extreme of what Z shows.
    always_comb begin
        w_data = Z;
        if (Overflow)
            w_data = Z[n-1] ? {1'b0, {(n-1){1'b1}}} : {1'b1, {(n-1){1'b0}}};
    end
`else
    always_comb begin
        w_data = Z;
    end
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_dropped <= 1'b0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (InValid && !w_push)
                r_dropped <= 1'b1;
            if (w_push && Overflow && r_ovf_cnt != 4'd15)
                r_ovf_cnt <= r_ovf_cnt + 4'd1;
        end
    end

    // Storage is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge Clock) begin
        if (w_push)
            r_mem[r_wptr] <= {Overflow, w_data};
    end
endmodule

// File: tb/tb_addsub_result_buffer.sv
// tb_addsub_result_buffer: directed scoreboard bench for addsub_result_buffer
module tb_addsub_result_buffer;
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [4:0] Z = '0;
    logic       Overflow = 1'b0;
    logic       InValid = 1'b0;
    logic       OutReady = 1'b0;
    logic [4:0] OutData;
    logic       OutOvf;
    logic       OutValid;
    logic       Full;
    logic       Dropped;
    logic [3:0] OvfCount;

    int checks = 0;
    int errors = 0;
    logic [5:0] sb [$];

    addsub_result_buffer #(.n(5), .DEPTH(4)) dut (
        .Clock(Clock), .Reset(Reset), .Z(Z), .Overflow(Overflow),
        .InValid(InValid), .OutReady(OutReady), .OutData(OutData),
        .OutOvf(OutOvf), .OutValid(OutValid), .Full(Full),
        .Dropped(Dropped), .OvfCount(OvfCount)
    );

    always #5 Clock = ~Clock;

    // Stored value expected for an accepted push.
    function automatic logic [5:0] expect_entry(input logic [4:0] z, input logic ovf);
`ifdef SAT_ON_OVERFLOW_EN
        if (ovf) return {1'b1, z[4] ? 5'b01111 : 5'b10000};
`endif
        return {ovf, z};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and return 1 time unit after the capturing edge.
    task automatic drive(input logic v, input logic [4:0] z, input logic ovf, input logic rdy, input logic accept);
        InValid = v;
        Z = z;
        Overflow = ovf;
        OutReady = rdy;
        if (accept) sb.push_back(expect_entry(z, ovf));
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 5'd0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        InValid = 1'b0;
        OutReady = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        sb.delete();
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    // Monitor: whenever the DUT offers an entry that will be taken, compare it.
    always @(negedge Clock) begin
        if (Reset && OutValid && OutReady) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no entry", {OutOvf, OutData});
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                if ({OutOvf, OutData} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", {OutOvf, OutData}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        #2 Reset = 1'b0;
        #6;
        chk("rst_outvalid", OutValid, 0);
        chk("rst_full", Full, 0);
        chk("rst_outdata", OutData, 0);
        chk("rst_outovf", OutOvf, 0);
        chk("rst_dropped", Dropped, 0);
        chk("rst_ovfcount", OvfCount, 0);
        @(negedge Clock);
        Reset = 1'b1;

        // First edge after reset accepts a push; one-cycle latency.
        drive(1, 5'b00011, 0, 0, 1);
        chk("single_valid", OutValid, 1);
        chk("single_data", OutData, 5'b00011);
        chk("single_ovf", OutOvf, 0);
        chk("single_full", Full, 0);
        idle(1);
        chk("single_drained", OutValid, 0);
        idle(1);
        chk("ready_while_empty", OutValid, 0);
        chk("empty_data_zero", OutData, 0);

        // Fill, overflow the buffer, then drain.
        for (int i = 1; i <= 4; i++) begin
            chk("fill_not_full", Full, 0);
            drive(1, 5'(i), 0, 0, 1);
        end
        chk("fill_full", Full, 1);
        chk("fill_no_drop", Dropped, 0);
        drive(1, 5'd9, 0, 0, 0);
        chk("drop_full", Full, 1);
        chk("drop_sticky", Dropped, 1);
        repeat (4) idle(1);
        chk("drained_valid", OutValid, 0);
        chk("drained_full", Full, 0);
        chk("drop_still_set", Dropped, 1);

        // Push and pop together while full.
        do_reset();
        chk("reset_clears_drop", Dropped, 0);
        for (int i = 1; i <= 4; i++) drive(1, 5'(i), 0, 0, 1);
        drive(1, 5'd7, 0, 1, 1);
        chk("pushpop_full", Full, 1);
        chk("pushpop_no_drop", Dropped, 0);
        chk("pushpop_head", OutData, 5'd2);
        repeat (4) idle(1);
        chk("pushpop_drained", OutValid, 0);

        // Overflowed results, both sign directions.
        drive(1, 5'b10010, 1, 0, 1);
        chk("ovf_outovf", OutOvf, 1);
`ifdef SAT_ON_OVERFLOW_EN
        chk("ovf_data_pos", OutData, 5'b01111);
`else
        chk("ovf_data_raw", OutData, 5'b10010);
`endif
        chk("ovf_count1", OvfCount, 1);
        drive(1, 5'b01100, 1, 0, 1);
        chk("ovf_count2", OvfCount, 2);
        idle(1);
`ifdef SAT_ON_OVERFLOW_EN
        chk("ovf_data_neg", OutData, 5'b10000);
`else
        chk("ovf_data_raw2", OutData, 5'b01100);
`endif
        idle(1);
        chk("ovf_drained", OutValid, 0);

        // OvfCount saturation under continuous pop.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 5'(i), 1, 1, 1);
            if (i == 13) chk("ovfcnt_14", OvfCount, 14);
            if (i == 14) chk("ovfcnt_15", OvfCount, 15);
        end
        chk("ovfcnt_sat", OvfCount, 15);
        chk("ovfcnt_no_drop", Dropped, 0);
        chk("ovfcnt_one_left", OutValid, 1);
        idle(1);
        chk("ovfcnt_drained", OutValid, 0);

        // Asynchronous reset mid-operation; refused ovf push must not count.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 5'(i + 20), 1, 0, 1);
        drive(1, 5'd30, 1, 0, 0);
        chk("pre_rst_full", Full, 1);
        chk("pre_rst_drop", Dropped, 1);
        chk("pre_rst_ovfcount", OvfCount, 4);
        #2 Reset = 1'b0;
        sb.delete();
        #1;
        chk("async_valid", OutValid, 0);
        chk("async_full", Full, 0);
        chk("async_ovfcount", OvfCount, 0);
        chk("async_dropped", Dropped, 0);
        chk("async_data", OutData, 0);
        @(negedge Clock);
        Reset = 1'b1;
        chk("post_rst_empty", OutValid, 0);
        drive(1, 5'd13, 0, 0, 1);
        chk("post_rst_head", OutData, 5'd13);
        idle(1);
        idle(0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
